// File: rtl/psk_frame_sched.sv
// PSK frame scheduler: wraps payload bytes in preamble/header (and an optional CRC-8 trailer), then idles for a gap.
// Define FRAME_SCHED_CRC8_EN to append the CRC-8 trailer byte; the default build ends the frame on the last body byte.
module psk_frame_sched #(
    parameter int PREAMBLE_LEN = 4,
    parameter int GAP_CYCLES   = 64
) (
    input  logic       clk_16M384,
    input  logic       rst_16M384,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic [3:0] frame_mode,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic [7:0] pl_tdata,
    input  logic       pl_tvalid,
    output logic       pl_tready,
    output logic [7:0] data_tdata,
    output logic       data_tvalid,
    output logic       data_tlast,
    output logic       data_tuser,
    input  logic       data_tready,
    output logic [3:0] MODE_CTRL
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, TRAILER, GAP} state_t;

    localparam logic [9:0] PRE_LAST = 10'(PREAMBLE_LEN - 1);
    localparam logic [9:0] GAP_LAST = 10'(GAP_CYCLES - 1);
`ifdef FRAME_SCHED_CRC8_EN
    localparam state_t BODY_NEXT = TRAILER;
`else
    localparam state_t BODY_NEXT = GAP;
`endif

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [7:0] len_q, len_d;
    logic [3:0] mode_q, mode_d;
    logic [7:0] crc_q, crc_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       mode_ok;

    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    assign mode_ok   = (frame_mode == 4'b0001) || (frame_mode == 4'b0010) || (frame_mode == 4'b0100);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign MODE_CTRL = mode_q;

    always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
        if (rst_16M384) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= 4'b0001;
            crc_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            crc_q   <= crc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        mode_d      = mode_q;
        crc_d       = crc_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        data_tvalid = 1'b0;
        data_tdata  = 8'h00;
        data_tlast  = 1'b0;
        data_tuser  = 1'b0;
        pl_tready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (mode_ok) begin
                        state_d = PREAMBLE;
                        cnt_d   = '0;
                        len_d   = frame_len;
                        mode_d  = frame_mode;
                        crc_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                data_tvalid = 1'b1;
                data_tdata  = 8'hAA;
                data_tuser  = (cnt_q == '0);
                if (data_tready) begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = HEADER;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            HEADER: begin
                data_tvalid = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    data_tdata = 8'h7E;
                    2'd1:    data_tdata = len_q;
                    default: data_tdata = {4'h0, mode_q};
                endcase
`ifndef FRAME_SCHED_CRC8_EN
                data_tlast = (cnt_q == 10'd2) && (len_q == 8'd0);
`endif
                if (data_tready) begin
                    crc_d = crc8_upd(crc_q, data_tdata);
                    if (cnt_q == 10'd2) begin
                        // Zero-length frames jump straight past the payload
                        state_d = (len_q == 8'd0) ? BODY_NEXT : PAYLOAD;
                        cnt_d   = {2'b00, len_q};
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            PAYLOAD: begin
                // cnt_q holds the payload bytes still owed to the modulator
                data_tvalid = pl_tvalid;
                data_tdata  = pl_tdata;
                pl_tready   = data_tready && (cnt_q != '0);
`ifndef FRAME_SCHED_CRC8_EN
                data_tlast = (cnt_q == 10'd1);
`endif
                if (pl_tvalid && data_tready) begin
                    crc_d = crc8_upd(crc_q, pl_tdata);
                    if (cnt_q == 10'd1) begin
                        state_d = BODY_NEXT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 10'd1;
                    end
                end
            end
            TRAILER: begin
                data_tvalid = 1'b1;
                data_tdata  = crc_q;
                data_tlast  = 1'b1;
                if (data_tready) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_psk_frame_sched.sv
// Self-checking bench for psk_frame_sched: vector table of frame requests plus random frames,
// checked against a byte-list reference model built from the frame format.
module tb_psk_frame_sched;

    localparam int PL  = 4;
    localparam int GAP = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] frame_len = '0;
    logic [3:0] frame_mode = '0;
    logic       busy, done, err;
    logic [7:0] pl_tdata = '0;
    logic       pl_tvalid = 1'b0;
    logic       pl_tready;
    logic [7:0] data_tdata;
    logic       data_tvalid, data_tlast, data_tuser;
    logic       data_tready = 1'b0;
    logic [3:0] MODE_CTRL;

    int n_cmp = 0;
    int n_mis = 0;
    logic [3:0] exp_mode = 4'b0001;

    always #5 clk = ~clk;

    psk_frame_sched #(.PREAMBLE_LEN(PL), .GAP_CYCLES(GAP)) dut (
        .clk_16M384(clk), .rst_16M384(rst), .start(start), .frame_len(frame_len),
        .frame_mode(frame_mode), .busy(busy), .done(done), .err(err),
        .pl_tdata(pl_tdata), .pl_tvalid(pl_tvalid), .pl_tready(pl_tready),
        .data_tdata(data_tdata), .data_tvalid(data_tvalid), .data_tlast(data_tlast),
        .data_tuser(data_tuser), .data_tready(data_tready), .MODE_CTRL(MODE_CTRL)
    );

    typedef struct {
        logic [3:0] mode;
        logic [7:0] len;
        int         rdy;
        int         vld;
        bit         fixed;
        bit         gap_start;
        bit         exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC-8 as polynomial long division, one message bit at a time
    function automatic logic [7:0] crc_ref(input logic [7:0] msg[$]);
        logic [7:0] r = 8'h00;
        logic       fb;
        foreach (msg[k])
            for (int b = 7; b >= 0; b--) begin
                fb = r[7] ^ msg[k][b];
                r  = {r[6:0], 1'b0};
                if (fb) r = r ^ 8'h07;
            end
        return r;
    endfunction

    task automatic chk_reset_outs(input string name);
        chk(name, {busy, done, err, pl_tready, data_tvalid, data_tlast, data_tuser, data_tdata, MODE_CTRL},
            {7'b0, 8'h00, 4'b0001});
    endtask

    task automatic run_err(input vec_t v);
        @(posedge clk); #1;
        start = 1'b1; frame_mode = v.mode; frame_len = v.len;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("err_pulse", err, 1'b1);
        chk("err_busy", busy, 1'b0);
        chk("err_mode_hold", MODE_CTRL, exp_mode);
        chk("err_no_valid", data_tvalid, 1'b0);
        @(posedge clk); #2;
        chk("err_one_cycle", err, 1'b0);
    endtask

    task automatic run_frame(input vec_t v);
        logic [7:0] pl_q[$];
        logic [7:0] body[$];
        logic [7:0] exp_q[$];
        int idx = 0, pl_idx = 0, cyc = 0, last_c = -1;
        bit pl_hold = 0, prev_stall = 0, finished = 0;
        logic [9:0] prev;

        for (int i = 0; i < v.len; i++) pl_q.push_back(v.fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom));
        for (int i = 0; i < PL; i++) exp_q.push_back(8'hAA);
        body.push_back(8'h7E); body.push_back(v.len); body.push_back({4'h0, v.mode});
        foreach (pl_q[i]) body.push_back(pl_q[i]);
        foreach (body[i]) exp_q.push_back(body[i]);
`ifdef FRAME_SCHED_CRC8_EN
        exp_q.push_back(crc_ref(body));
`endif
        exp_mode = v.mode;

        @(posedge clk); #1;
        start = 1'b1; frame_mode = v.mode; frame_len = v.len;
        data_tready = 1'b0; pl_tvalid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (!finished && cyc < 20000) begin
            cyc++;
            data_tready = ($urandom_range(99) < v.rdy);
            start = v.gap_start && (last_c >= 0) && (cyc - last_c == 5);
            if (!pl_hold) begin
                pl_tvalid = (pl_idx < int'(v.len)) && ($urandom_range(99) < v.vld);
                pl_tdata  = pl_tvalid ? pl_q[pl_idx] : 8'($urandom);
            end
            #1;
            if (cyc == 1) begin
                chk("first_valid", {data_tvalid, data_tuser, data_tdata}, {2'b11, 8'hAA});
                chk("busy_after_accept", busy, 1'b1);
                chk("mode_ctrl_update", MODE_CTRL, v.mode);
            end
            if (idx < exp_q.size()) begin
                if (!busy) chk("busy_in_frame", busy, 1'b1);
                if (v.len == 0) chk("len0_pl_tready", pl_tready, 1'b0);
                if (prev_stall) chk("stall_stable", {data_tvalid, data_tlast, data_tuser, data_tdata}, {1'b1, prev});
                if (data_tvalid && data_tready) begin
                    chk($sformatf("byte%0d", idx), data_tdata, exp_q[idx]);
                    chk($sformatf("tlast%0d", idx), data_tlast, idx == exp_q.size() - 1);
                    chk($sformatf("tuser%0d", idx), data_tuser, idx == 0);
                    idx++;
                    if (idx == exp_q.size()) last_c = cyc;
                end
                prev_stall = data_tvalid && !data_tready;
                prev = {data_tlast, data_tuser, data_tdata};
            end else if (cyc - last_c <= GAP) begin
                if (data_tvalid || done || err || !busy)
                    chk("gap_quiet", {data_tvalid, done, err, busy}, 4'b0001);
            end else begin
                chk("done_timing", done, 1'b1);
                chk("done_busy_low", busy, 1'b0);
                chk("pl_all_consumed", pl_idx, v.len);
                finished = 1;
            end
            if (pl_tvalid && pl_tready) pl_idx++;
            pl_hold = pl_tvalid && !pl_tready;
            if (!finished) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0; pl_tvalid = 1'b0;
        if (!finished) chk("frame_timeout", 0, 1);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4'b0001, 8'd2,   100, 100, 1, 0, 0};
        vecs[1] = '{4'b0011, 8'd5,   100, 100, 0, 0, 1};
        vecs[2] = '{4'b0100, 8'd0,   100, 100, 0, 0, 0};
        vecs[3] = '{4'b0010, 8'd255, 60,  70,  0, 0, 0};
        vecs[4] = '{4'b0100, 8'd17,  50,  50,  0, 1, 0};
        vecs[5] = '{4'b0000, 8'd3,   100, 100, 0, 0, 1};
        vecs[6] = '{4'b1000, 8'd3,   100, 100, 0, 0, 1};
        vecs[7] = '{4'b0001, 8'd1,   80,  40,  0, 0, 0};
        vecs[8] = '{4'b0010, 8'd40,  30,  90,  0, 1, 0};

        data_tready = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk_reset_outs("reset_async");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("reset_held");
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].exp_err) run_err(vecs[i]);
            else                 run_frame(vecs[i]);
        end

        for (int r = 0; r < 6; r++) begin
            vec_t v;
            v.mode      = 4'($urandom_range(15));
            if (r < 3) v.mode = 4'(1 << $urandom_range(2));
            v.len       = 8'($urandom_range(255));
            v.rdy       = 20 + $urandom_range(80);
            v.vld       = 20 + $urandom_range(80);
            v.fixed     = 0;
            v.gap_start = $urandom_range(1);
            v.exp_err   = !(v.mode inside {4'b0001, 4'b0010, 4'b0100});
            if (v.exp_err) run_err(v);
            else           run_frame(v);
        end

        // Reset in the middle of the payload, then a clean frame afterwards
        @(posedge clk); #1;
        start = 1'b1; frame_mode = 4'b0010; frame_len = 8'd10;
        @(posedge clk); #1;
        start = 1'b0; data_tready = 1'b1; pl_tvalid = 1'b1; pl_tdata = 8'h5C;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_reset_payload", pl_tready, 1'b1);
        rst = 1'b1;
        #1;
        chk_reset_outs("reset_mid_frame");
        @(posedge clk); #1;
        rst = 1'b0; pl_tvalid = 1'b0;
        exp_mode = 4'b0001;
        #1;
        chk_reset_outs("after_release");
        run_frame('{4'b0001, 8'd3, 100, 100, 0, 0, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
